display_scanner: RTL and testbench
==================================

Name: display_scanner

Overview:
- Time-multiplexed scan controller for the 8-digit 7-segment display. It drives the channel/data inputs of the existing combinational segment/digit-select decoder.
- Holds an 8-entry digit register file written by the clock/counter logic.
- Steps through digits 1..8 at a fixed scan rate, presenting one channel number and one 4-bit digit code at a time.
- Supports per-digit blinking, used for time-setting mode, and emits a frame-start pulse.

Parameters:
- SCAN_DIV, 50000, clk cycles each digit stays active (≥2)
- BLINK_DIV, 12500000, clk cycles per blink phase toggle (≥2)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write strobe for the digit register file
- wr_addr  in  3  digit index 0..7 (index i drives channel i+1)
- wr_data  in  4  digit code: 0..9 digit, 10 bar; 11..15 are clamped to 10 on write
- blink_mask  in  8  bit i=1 makes digit i blink
- channel  out  8  active digit select to the decoder, values 1..8 only
- data  out  4  digit code to the decoder, values 0..10 only
- frame_start  out  1  one-cycle pulse when the scan wraps from digit 8 to digit 1

Behaviour:
- Reset (async assert, sync-to-clk deassert by design):
  - digit regs = 0, scan index idx = 0, prescaler = 0
  - blink counter = 0, blink_phase = 0
  - channel = 8'd1, data = 4'd0, frame_start = 0
- Channel is never driven to 0 or >8, because the decoder holds its previous select for uncovered values. Data is never driven >10 for the same reason.
- Scan prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - scan_tick = (prescaler == SCAN_DIV-1).
  - On scan_tick, idx <= (idx==7) ? 0 : idx+1.
- All outputs are registered:
  - channel <= idx_next + 1
  - data <= eff(idx_next)
  - frame_start <= scan_tick && idx==7
- Each digit is therefore active for exactly SCAN_DIV consecutive cycles. A full frame is 8*SCAN_DIV cycles.
- eff(i) = (blink_phase && blink_mask[i]) ? 4'd10 : digit_next[i].
- digit_next[i] includes the same-cycle write (write bypass). A write in cycle N to the digit active at N+1 appears on data at N+1.
- Write: on wr_en, digit[wr_addr] <= clamp(wr_data). A write concurrent with scan_tick is not lost; both take effect.
- Blink: an independent counter 0..BLINK_DIV-1 toggles blink_phase on wrap.
  - The blink counter is free-running and not aligned to frames.
  - A blink_mask change takes effect on data the next cycle.
- Reset mid-scan: outputs return to their reset values immediately (asynchronously). Digit contents are lost.
- No handshake. Register writes are always accepted in one cycle.

Decomposition:
- Shared package seg_pkg:
  - NUM_DIGITS=8, DIGIT_W=4, DIGIT_BAR=4'd10
  - digit-code constants 0..9
  - CHANNEL_FIRST=8'd1, CHANNEL_LAST=8'd8
  - The decoder also uses this package for its case items.
- Sub-module tick_gen (parameter DIV): modulo counter with async reset that outputs a 1-cycle tick on wrap. It is instantiated twice, once for the scan and once for the blink.

Test Plan (SCAN_DIV=4, BLINK_DIV=10 unless noted):
- Reset, then run 40 cycles → channel sequence 1,1,1,1,2,2,2,2,...,8,8,8,8,1. frame_start is high for exactly one cycle, coincident with the first cycle of channel=1 after wrapping from 8. Data=0 throughout.
- Write codes 0..7 to addresses 0..7, then run one frame → whenever channel=k, data=k-1. The value/channel pairing is never skewed across a digit boundary.
- Write wr_addr=3, wr_data=4'd13 → when channel=4, data=10 (clamped). Also check that channel and data never exceed 8 and 10 over 1000 random-write cycles.
- blink_mask=8'b0000_0100, digit2=5, BLINK_DIV=10 → while channel=3, data alternates 5 (blink_phase=0) and 10 (blink_phase=1), switching every 10 cycles. Other digits are unaffected.
- Write digit4=9 in the same cycle as the scan_tick that advances to channel 5 → the next cycle shows channel=5, data=9.
- Assert rst asynchronously mid-frame while channel=6 → outputs immediately show channel=1, data=0, frame_start=0. After deassert, scanning restarts from channel 1 with a full 4-cycle dwell.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display path: digit codes, channel
// range and the write-side clamp used by the scan controller and the decoder.
package seg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 4;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    typedef logic [DIGIT_W-1:0] digit_t;
    typedef logic [IDX_W-1:0]   idx_t;
    typedef logic [7:0]         channel_t;

    localparam digit_t DIGIT_0   = 4'd0;
    localparam digit_t DIGIT_1   = 4'd1;
    localparam digit_t DIGIT_2   = 4'd2;
    localparam digit_t DIGIT_3   = 4'd3;
    localparam digit_t DIGIT_4   = 4'd4;
    localparam digit_t DIGIT_5   = 4'd5;
    localparam digit_t DIGIT_6   = 4'd6;
    localparam digit_t DIGIT_7   = 4'd7;
    localparam digit_t DIGIT_8   = 4'd8;
    localparam digit_t DIGIT_9   = 4'd9;
    localparam digit_t DIGIT_BAR = 4'd10;

    localparam channel_t CHANNEL_FIRST = 8'd1;
    localparam channel_t CHANNEL_LAST  = 8'd8;

    localparam idx_t IDX_LAST = idx_t'(NUM_DIGITS - 1);

    // Codes the decoder does not cover are stored as a bar so they can never reach it.
    function automatic digit_t clamp_digit(input digit_t code);
        return (code > DIGIT_9) ? DIGIT_BAR : code;
    endfunction

endpackage

// File: rtl/display_scanner_tick_gen.sv
// Free-running modulo-DIV counter; tick is high during the last count value,
// i.e. for one cycle per DIV cycles, just before the counter wraps to zero.
module tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed scan controller for the 8-digit 7-segment display: holds the
// digit register file and presents one registered channel/data pair per dwell.
import seg_pkg::*;

module display_scanner #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic [7:0] blink_mask,
    output logic [7:0] channel,
    output logic [3:0] data,
    output logic       frame_start
);

    digit_t digits      [NUM_DIGITS];
    digit_t digits_next [NUM_DIGITS];
    idx_t   idx;
    idx_t   idx_next;
    logic   scan_tick;
    logic   blink_tick;
    logic   blink_phase;

    tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (scan_tick)
    );

    tick_gen #(.DIV(BLINK_DIV)) u_blink_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (blink_tick)
    );

    // The write is folded in here so the output stage sees a digit written in
    // the same cycle it is selected, without a one-dwell lag.
    // NOTE: every signal assigned in always_comb gets a default first; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        digits_next = digits;
        if (wr_en) begin
            digits_next[wr_addr] = clamp_digit(wr_data);
        end

        idx_next = idx;
        if (scan_tick) begin
            idx_next = (idx == IDX_LAST) ? '0 : idx + idx_t'(1);
        end
    end

    // Outputs are computed from the next-state index so channel and data
    // change on the same edge as idx and never skew across a digit boundary.
    // NOTE: the digit file is small and must read as zero after reset, so it is
    // reset like ordinary flops; a large RAM-style array would not be.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digits[i] <= DIGIT_0;
            end
            idx         <= '0;
            blink_phase <= 1'b0;
            channel     <= CHANNEL_FIRST;
            data        <= DIGIT_0;
            frame_start <= 1'b0;
        end else begin
            digits <= digits_next;
            idx    <= idx_next;
            if (blink_tick) begin
                blink_phase <= ~blink_phase;
            end
            channel     <= CHANNEL_FIRST + channel_t'(idx_next);
            data        <= (blink_phase && blink_mask[idx_next]) ? DIGIT_BAR
                                                                 : digits_next[idx_next];
            frame_start <= scan_tick && (idx == IDX_LAST);
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with SCAN_DIV=4, BLINK_DIV=10; expected
// values come from closed-form cycle arithmetic counted from reset release.
module tb_display_scanner;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic [7:0] blink_mask;
    logic [7:0] channel;
    logic [3:0] data;
    logic       frame_start;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    display_scanner #(
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .blink_mask  (blink_mask),
        .channel     (channel),
        .data        (data),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, observed, expected);
        end
    endtask

    // One clock edge; outputs are then sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Channel after c edges since reset release: each digit dwells 4 cycles.
    function automatic int exp_channel(input int c);
        return ((c / SCAN_DIV) % 8) + 1;
    endfunction

    function automatic int exp_frame(input int c);
        return (c > 0 && (c % (8 * SCAN_DIV)) == 0) ? 1 : 0;
    endfunction

    // Blink phase seen by the output stage at edge c (phase held before that edge).
    function automatic int exp_phase(input int c);
        return ((c - 1) / BLINK_DIV) % 2;
    endfunction

    initial begin
        rst        = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        blink_mask = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;

        check("reset_channel", int'(channel), 1);
        check("reset_data", int'(data), 0);
        check("reset_frame", int'(frame_start), 0);

        // Plain scan over more than one frame, empty digit file.
        for (int i = 0; i < 40; i++) begin
            step();
            check("scan_channel", int'(channel), exp_channel(cyc));
            check("scan_frame", int'(frame_start), exp_frame(cyc));
            check("scan_data", int'(data), 0);
        end

        // Load codes 0..7 and verify channel/data pairing over one frame.
        for (int a = 0; a < 8; a++) begin
            wr_en   = 1'b1;
            wr_addr = 3'(a);
            wr_data = 4'(a);
            step();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            step();
            check("pair_channel", int'(channel), exp_channel(cyc));
            check("pair_data", int'(data), exp_channel(cyc) - 1);
        end

        // Out-of-range code is clamped to the bar.
        wr_en   = 1'b1;
        wr_addr = 3'd3;
        wr_data = 4'd13;
        step();
        wr_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            step();
            check("clamp_data", int'(data),
                  (exp_channel(cyc) == 4) ? 10 : exp_channel(cyc) - 1);
        end

        // Random writes and masks: outputs stay in range, scan timing unaffected.
        for (int i = 0; i < 1000; i++) begin
            wr_en      = 1'($urandom_range(0, 1));
            wr_addr    = 3'($urandom_range(0, 7));
            wr_data    = 4'($urandom_range(0, 15));
            blink_mask = 8'($urandom);
            step();
            check("rand_ch_range", int'(channel >= 8'd1 && channel <= 8'd8), 1);
            check("rand_data_range", int'(data <= 4'd10), 1);
            check("rand_channel", int'(channel), exp_channel(cyc));
        end

        // Fresh reset so the blink counter position is known.
        wr_en      = 1'b0;
        blink_mask = '0;
        rst        = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        check("rst2_channel", int'(channel), 1);
        check("rst2_data", int'(data), 0);

        // Digit 2 = 5 blinking; mask dropped at cycle 73 takes effect on cycle 74.
        wr_en      = 1'b1;
        wr_addr    = 3'd2;
        wr_data    = 4'd5;
        blink_mask = 8'b0000_0100;
        step();
        wr_en = 1'b0;
        check("blink_first", int'(data), 0);
        while (cyc < 100) begin
            if (cyc == 73) blink_mask = 8'h00;
            step();
            check("blink_channel", int'(channel), exp_channel(cyc));
            if (exp_channel(cyc) == 3)
                check("blink_data", int'(data),
                      (exp_phase(cyc) == 1 && blink_mask[2]) ? 10 : 5);
            else
                check("blink_other", int'(data), 0);
        end

        // Preload digit 5 so the async reset check sees data drop.
        wr_en   = 1'b1;
        wr_addr = 3'd5;
        wr_data = 4'd7;
        step();
        wr_en = 1'b0;
        while (cyc < 111) step();

        // Cycle 111 carries the scan tick into channel 5: write digit 4 alongside it.
        wr_en   = 1'b1;
        wr_addr = 3'd4;
        wr_data = 4'd9;
        step();
        wr_en = 1'b0;
        check("bypass_channel", int'(channel), 5);
        check("bypass_data", int'(data), 9);
        step();
        check("bypass_hold", int'(data), 9);

        // Asynchronous reset while channel 6 is showing.
        while (cyc < 117) step();
        check("pre_rst_channel", int'(channel), 6);
        check("pre_rst_data", int'(data), 7);
        #2;
        rst = 1'b1;
        #1;
        check("async_channel", int'(channel), 1);
        check("async_data", int'(data), 0);
        check("async_frame", int'(frame_start), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("restart_channel", int'(channel), exp_channel(cyc));
            check("restart_data", int'(data), 0);
            check("restart_frame", int'(frame_start), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
